// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers,
// a four-state countdown FSM and one registered interrupt request line.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q;
    logic        wr_ctrl, wr_preset;
    logic        unused_addr_lsb;

    // Bus handshake: a store is accepted in the single cycle where we & hit is high;
    // the target never stalls and read data is valid in the same cycle as the address.
    assign hit             = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl         = we & hit & (addr[3:2] == 2'd0);
    assign wr_preset       = we & hit & (addr[3:2] == 2'd1);
    assign unused_addr_lsb = ^addr[1:0];

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rdata = {28'd0, ctrl_q};
                2'd1:    rdata = preset_q;
                2'd2:    rdata = count_q;
                default: rdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                // MODE 01 reloads; the other three encodings stop after one shot.
                if (ctrl_q[2:1] == 2'b01) begin
                    irq_flag_d = 1'b0;
                    state_d    = ctrl_q[0] ? S_LOAD : S_IDLE;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes are applied last so they override the FSM's own updates.
        if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];
        if (wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (byteen[i]) preset_d[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_flag_d & ctrl_d[3];
        end
    end

    assign irq       = irq_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios with literal expectations,
// then randomized bus traffic checked every cycle against a behavioural model.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    localparam int PH_IDLE    = 0;
    localparam int PH_LOAD    = 1;
    localparam int PH_COUNT   = 2;
    localparam int PH_EXPIRED = 3;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .byteen   (byteen),
        .hit      (hit),
        .rdata    (rdata),
        .irq      (irq),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [3:0]  m_ctrl   = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count  = 32'd0;
    logic        m_flag   = 1'b0;
    int          m_phase  = PH_IDLE;

    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count;
    logic        n_flag, sel_win, to_ctrl, to_preset;
    int          n_phase;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = PH_IDLE;
        end else begin
            sel_win   = we && (addr[31:4] == BASE[31:4]);
            to_ctrl   = sel_win && (addr[3:2] == 2'd0);
            to_preset = sel_win && (addr[3:2] == 2'd1);
            n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_flag = m_flag; n_phase = m_phase;
            if (m_phase == PH_IDLE) begin
                if (m_ctrl[0]) n_phase = PH_LOAD;
            end else if (m_phase == PH_LOAD) begin
                n_count = m_preset;
                n_phase = PH_COUNT;
            end else if (m_phase == PH_COUNT) begin
                if (!m_ctrl[0]) n_phase = PH_IDLE;
                else if (m_count <= 32'd1) begin
                    n_count = 32'd0; n_flag = 1'b1; n_phase = PH_EXPIRED;
                end else n_count = m_count - 32'd1;
            end else begin
                if (m_ctrl[2:1] == 2'b01) begin
                    n_flag  = 1'b0;
                    n_phase = m_ctrl[0] ? PH_LOAD : PH_IDLE;
                end else begin
                    n_ctrl[0] = 1'b0;
                    n_phase   = PH_IDLE;
                end
            end
            if (to_ctrl && byteen[0]) n_ctrl = wdata[3:0];
            if (to_preset)
                for (int b = 0; b < 4; b++)
                    if (byteen[b]) n_preset[b*8 +: 8] = wdata[b*8 +: 8];
            if (to_ctrl || to_preset) n_flag = 1'b0;
            m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_flag = n_flag; m_phase = n_phase;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard: every cycle against the model ----------------
    always @(negedge clk) begin
        check("hit_model", {31'd0, hit}, {31'd0, addr[31:4] == BASE[31:4]});
        check("rdata_model", rdata, model_read(addr));
        check("irq_model", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
    end

    // ---------------- driver tasks ----------------
    task automatic write_reg(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        addr = BASE + off; we = 1'b1; wdata = data; byteen = be;
        @(posedge clk); #1;
        we = 1'b0; byteen = 4'd0;
    endtask

    task automatic read_check(input string name, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] e;
        addr = BASE + off; we = 1'b0;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check(name, rdata, e);
    endtask

    task automatic rand_drive();
        int r;
        r = $urandom_range(0, 99);
        we = 1'b0; wdata = $urandom; byteen = 4'($urandom_range(0, 15));
        if (r < 55) begin
            addr = BASE + 32'($urandom_range(0, 3) * 4);
        end else if (r < 62) begin
            addr = $urandom; we = ($urandom_range(0, 1) == 1);
        end else if (r < 78) begin
            addr = BASE; we = 1'b1;
            wdata[0]  = ($urandom_range(0, 3) != 0);
            byteen[0] = ($urandom_range(0, 4) != 0);
        end else if (r < 93) begin
            addr = BASE + 32'd4; we = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                wdata = 32'($urandom_range(0, 6)); byteen = 4'hF;
            end
        end else begin
            addr = BASE + 32'($urandom_range(2, 4) * 4); we = 1'b1;
        end
        if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0; #2; reset = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] os_cnt [6];
    logic        os_irq [6];
    int          pulses;

    initial begin
        os_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
        os_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reset = 1'b1; we = 1'b0; addr = BASE; wdata = 32'd0; byteen = 4'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // reset values
        @(negedge clk); #1;
        read_check("rst_ctrl", 32'd0, 32'd0);
        read_check("rst_preset", 32'd4, 32'd0);
        read_check("rst_count", 32'd8, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // one-shot, PRESET=3, irq at e0+5 and sticky
        write_reg(32'd4, 32'd3, 4'hF);
        write_reg(32'd0, 32'h9, 4'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            read_check("os_count", 32'd8, os_cnt[k]);
            check("os_irq", {31'd0, irq}, {31'd0, os_irq[k]});
        end
        @(negedge clk); #1;
        read_check("os_ctrl_en_cleared", 32'd0, 32'h8);
        read_check("os_count_hold", 32'd8, 32'd0);
        check("os_irq_sticky", {31'd0, irq}, 32'd1);
        write_reg(32'd0, 32'h8, 4'h1);
        @(negedge clk); #1;
        check("os_irq_cleared", {31'd0, irq}, 32'd0);

        // auto-reload, PRESET=2: one-cycle pulse every 4 cycles
        write_reg(32'd4, 32'd2, 4'hF);
        write_reg(32'd0, 32'hB, 4'hF);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk); #1;
            check("ar_irq", {31'd0, irq}, {31'd0, (k >= 4) && (k % 4 == 0)});
            if (irq) pulses++;
        end
        check("ar_pulses", 32'(pulses), 32'd3);
        write_reg(32'd0, 32'hA, 4'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            read_check("ar_frozen_count", 32'd8, 32'd1);
            check("ar_stopped_irq", {31'd0, irq}, 32'd0);
        end

        // byte masking and ignored writes
        write_reg(32'd4, 32'h1122_3344, 4'hF);
        write_reg(32'd4, 32'hAABB_CCDD, 4'b0100);
        @(negedge clk); #1;
        read_check("mask_preset", 32'd4, 32'h11BB_3344);
        write_reg(32'd8, 32'hFFFF_FFFF, 4'hF);
        write_reg(32'hC, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk); #1;
        read_check("ro_preset", 32'd4, 32'h11BB_3344);
        read_check("ro_ctrl", 32'd0, 32'hA);
        read_check("ro_count", 32'd8, 32'd1);
        read_check("ro_off_c", 32'hC, 32'd0);

        // decode
        @(negedge clk); #1;
        addr = BASE + 32'h10; we = 1'b1; wdata = 32'hFFFF_FFFF; byteen = 4'hF;
        #1;
        check("dec_miss_hit", {31'd0, hit}, 32'd0);
        check("dec_miss_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        we = 1'b0; byteen = 4'd0;
        @(negedge clk); #1;
        read_check("dec_preset", 32'd4, 32'h11BB_3344);
        check("dec_hit", {31'd0, hit}, 32'd1);
        read_check("dec_ctrl", 32'd0, 32'hA);

        // PRESET=0 with IM=0, then CTRL=0x9 clears the hidden flag
        write_reg(32'd4, 32'd0, 4'hF);
        write_reg(32'd0, 32'h1, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            read_check("p0_count", 32'd8, (k < 2) ? 32'd1 : 32'd0);
            read_check("p0_ctrl", 32'd0, (k < 4) ? 32'd1 : 32'd0);
            check("p0_irq_masked", {31'd0, irq}, 32'd0);
        end
        write_reg(32'd0, 32'h9, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("p0_irq_after_clear", {31'd0, irq}, {31'd0, k == 3});
        end

        // asynchronous reset mid-count
        write_reg(32'd4, 32'd8, 4'hF);
        write_reg(32'd0, 32'h9, 4'hF);
        for (int k = 0; k < 6; k++) @(negedge clk);
        #1;
        read_check("mid_count", 32'd8, 32'd5);
        reset = 1'b0;
        #1;
        read_check("arst_ctrl", 32'd0, 32'd0);
        read_check("arst_preset", 32'd4, 32'd0);
        read_check("arst_count", 32'd8, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            read_check("post_rst_count", 32'd8, 32'd0);
            read_check("post_rst_ctrl", 32'd0, 32'd0);
            check("post_rst_irq", {31'd0, irq}, 32'd0);
        end

        // randomized traffic, checked every cycle by the scoreboard process
        @(posedge clk); #1;
        for (int c = 0; c < 1500; c++) begin
            rand_drive();
            @(posedge clk); #1;
        end
        we = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped countdown timer that sits on the CPU's M-stage data bus as a bus target. It decodes the CPU's address, write-enable, write-data and byte-enable outputs, and returns read data combinationally in the same cycle. It counts down from a programmed preset and drives one bit of the CPU's 6-bit `interruptrequest` input.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00. 16-byte aligned base of the register window.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `addr` input 32: byte address from the CPU (`addr_cpu`).
- `we` input 1: write strobe (`we_cpu`), single cycle per store.
- `wdata` input 32: lane-aligned store data (`data_cpu`).
- `byteen` input 4: byte-lane enables (`m_data_byteen`).
- `hit` output 1: combinational; 1 when `addr[31:4] == BASE_ADDR[31:4]`.
- `rdata` output 32: combinational read data for the selected register; 0 when `hit`=0.
- `irq` output 1: interrupt request, registered (`irq_flag & CTRL.IM`).

## Operation
- **Register map**, selected by `addr[3:2]`. Writes occur only when `we & hit`.
  - 0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM. Bits[31:4] read 0 and ignore writes.
  - 1 PRESET: 32-bit, read/write.
  - 2 COUNT: read-only; writes are ignored.
  - 3: reads 0; writes are ignored.
- **Byte masking:** a write updates only the lanes whose `byteen` bit is set. `wdata` is already lane-aligned, so no shifting is applied.
- **MODE:** 00 is one-shot and 01 is auto-reload. 10 and 11 behave as 00.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT held.
    - Otherwise, if COUNT > 1, COUNT <= COUNT-1.
    - Otherwise (COUNT is 0 or 1), COUNT <= 0, irq_flag <= 1, and go to INT.
  - INT, one-shot: CTRL.EN <= 0; go to IDLE; irq_flag stays set.
  - INT, auto-reload: irq_flag <= 0; go to LOAD.
- **irq_flag clear:** any bus write to CTRL or PRESET clears irq_flag. If it coincides with a flag set in the same cycle, the clear wins.
- **Simultaneous events:**
  - A bus write to CTRL in the same cycle as INT's EN clear: the bus value wins.
  - CTRL.EN written to 0 in any state: the FSM is in IDLE after the next edge, except from LOAD, which completes its load first and then exits from CNT.
  - A PRESET write during CNT does not change COUNT until the next LOAD.
- **Reset** (asynchronous, `reset`=0), immediately: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, `irq`=0. Reset mid-count abandons the count with no irq.

## Timing
- `rdata` and `hit` are pure combinational functions of `addr` and the current registers. A read in the same cycle as a write returns the old value.
- Write of EN=1 at edge e0: LOAD at e1; COUNT=N and state CNT at e2; COUNT decrements once per edge.
- For PRESET N≥1, the flag sets at edge e0+N+2. N=0 behaves as N=1, with the flag at e0+3.
- `irq` follows `irq_flag & IM` in the same cycle as the register updates.
- Auto-reload period is N+2 cycles (N CNT + INT + LOAD). `irq` is high for exactly 1 cycle per period when IM=1.
- One-shot: `irq` stays high until software writes CTRL or PRESET.
- COUNT holds 0 after a one-shot expiry until the next LOAD.

## Test plan
- **Reset:** assert `reset`=0 mid-count with COUNT=5 → all registers read 0 immediately, `irq`=0, and the FSM stays IDLE after release.
- **One-shot:** PRESET=3, then CTRL=0x9 (EN, IM, mode 00) at e0 → COUNT reads 3,2,1,0; `irq` rises at e0+5 and stays high; CTRL reads 0x8. A write of CTRL=0x8 drops `irq` the next cycle.
- **Auto-reload:** PRESET=2, CTRL=0xB → `irq` is a 1-cycle pulse every 4 cycles. Clearing EN mid-count freezes COUNT and stops the pulses.
- **Byte masking:** write PRESET with wdata=0xAABBCCDD, byteen=0100 over PRESET=0x11223344 → reads 0x11BB3344. A write to COUNT or offset 0xC leaves all registers unchanged.
- **Decode:** addr=BASE_ADDR+0x10 with we=1 → `hit`=0, `rdata`=0, no register change. addr=BASE_ADDR+4 → `hit`=1 and `rdata`=PRESET.
- **Masked and edge preset:** PRESET=0, CTRL=0x1 (IM=0) → the flag sets at e0+3 and `irq` stays 0. A subsequent CTRL=0x9 write clears the flag, so `irq` stays 0 until the next expiry.
